// File: rtl/glm_rd_streamer.sv
// glm_rd_streamer: streams a (base, count) job as single-line c0 reads and returns tagged response lines.
// Optional almFull statistics counter is built only when GLM_RD_STATS_EN is defined.
package glm_rd_streamer_pkg;
    typedef logic [41:0] t_ccip_clAddr;
    typedef logic [15:0] t_ccip_mdata;
    typedef enum logic [1:0] {eVC_VA = 2'h0, eVC_VL0 = 2'h1, eVC_VH0 = 2'h2, eVC_VH1 = 2'h3} t_ccip_vc;
    typedef enum logic [1:0] {eCL_LEN_1 = 2'h0, eCL_LEN_2 = 2'h1, eCL_LEN_4 = 2'h3} t_ccip_clLen;
    typedef enum logic [3:0] {eREQ_RDLINE_I = 4'h0, eREQ_RDLINE_S = 4'h1} t_ccip_c0_req;
    typedef enum logic [3:0] {eRSP_RDLINE = 4'h0, eRSP_UMSG = 4'h4} t_ccip_c0_rsp;

    typedef struct packed {
        t_ccip_vc     vc_sel;
        logic [1:0]   rsvd1;
        t_ccip_clLen  cl_len;
        t_ccip_c0_req req_type;
        logic [5:0]   rsvd0;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c0_ReqMemHdr;

    typedef struct packed {
        t_ccip_c0_ReqMemHdr hdr;
        logic               valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        t_ccip_vc     vc_used;
        logic         rsvd1;
        logic         hit_miss;
        logic [1:0]   rsvd0;
        logic [1:0]   cl_num;
        t_ccip_c0_rsp resp_type;
        t_ccip_mdata  mdata;
    } t_ccip_c0_RspMemHdr;

    typedef struct packed {
        t_ccip_c0_RspMemHdr hdr;
        logic [511:0]       data;
        logic               rspValid;
        logic               mmioRdValid;
        logic               mmioWrValid;
    } t_if_ccip_c0_Rx;
endpackage

module glm_rd_streamer
    import glm_rd_streamer_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 64,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  t_ccip_clAddr     base_addr,
    input  logic [CNT_W-1:0] num_lines,
    input  logic             c0TxAlmFull,
    output t_if_ccip_c0_Tx   c0Tx,
    input  t_if_ccip_c0_Rx   c0Rx,
    output logic             rd_valid,
    output logic [511:0]     rd_data,
    output logic [15:0]      rd_tag,
    output logic             busy,
    output logic             done,
    output logic [31:0]      stat_almfull_cycles
);
    localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} t_state;

    t_state           r_state, w_next;
    t_ccip_clAddr     r_base;
    logic [CNT_W-1:0] r_num, r_issued, r_received;
    logic [OW-1:0]    r_outstanding;
    logic             r_done, r_rd_valid;
    logic [511:0]     r_rd_data;
    logic [15:0]      r_rd_tag;
    t_if_ccip_c0_Tx   r_c0tx;
    logic             w_accept, w_issue, w_rsp, w_busy, w_more;

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = (w_accept && num_lines != '0) ? ISSUE : IDLE;
            ISSUE:   w_next = (w_issue && r_issued + CNT_W'(1) == r_num) ? DRAIN : ISSUE;
            DRAIN:   w_next = (r_received == r_num) ? IDLE : DRAIN;
            default: w_next = IDLE;
        endcase
    end

    // Responses are only accepted while a job is live; stale lines after reset are dropped.
    always_comb begin
        w_busy   = r_state != IDLE;
        w_more   = r_issued < r_num;
        w_accept = start && !w_busy;
        w_issue  = r_state == ISSUE && !c0TxAlmFull && r_outstanding < OW'(MAX_OUTSTANDING) && w_more;
        w_rsp    = w_busy && c0Rx.rspValid && c0Rx.hdr.resp_type == eRSP_RDLINE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_base        <= '0;
            r_num         <= '0;
            r_issued      <= '0;
            r_received    <= '0;
            r_outstanding <= '0;
            r_done        <= 1'b0;
            r_c0tx        <= '0;
            r_rd_valid    <= 1'b0;
            r_rd_data     <= '0;
            r_rd_tag      <= '0;
        end else begin
            if (w_accept) begin
                r_base        <= base_addr;
                r_num         <= num_lines;
                r_issued      <= '0;
                r_received    <= '0;
                r_outstanding <= '0;
                r_done        <= num_lines == '0;
            end else begin
                if (w_issue) r_issued <= r_issued + CNT_W'(1);
                if (w_rsp) r_received <= r_received + CNT_W'(1);
                r_outstanding <= r_outstanding + OW'(w_issue) - OW'(w_rsp);
                if (r_state == DRAIN && r_received == r_num) r_done <= 1'b1;
            end
            r_c0tx.valid <= w_issue;
            if (w_issue) begin
                r_c0tx.hdr <= '{
                    vc_sel:   eVC_VA,
                    rsvd1:    '0,
                    cl_len:   eCL_LEN_1,
                    req_type: eREQ_RDLINE_I,
                    rsvd0:    '0,
                    address:  r_base + 42'(r_issued),
                    mdata:    16'(r_issued)
                };
            end
            r_rd_valid <= w_rsp;
            if (w_rsp) begin
                r_rd_data <= c0Rx.data;
                r_rd_tag  <= c0Rx.hdr.mdata;
            end
        end
    end

`ifdef GLM_RD_STATS_EN
    logic [31:0] r_stat;

    always_ff @(posedge clk) begin
        if (reset || w_accept) r_stat <= '0;
        else if (r_state == ISSUE && c0TxAlmFull && w_more && r_stat != '1) r_stat <= r_stat + 32'd1;
    end

    assign stat_almfull_cycles = r_stat;
`else
    assign stat_almfull_cycles = '0;
`endif

    assign c0Tx     = r_c0tx;
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
    assign rd_tag   = r_rd_tag;
    assign busy     = w_busy;
    assign done     = r_done;
endmodule

// File: tb/tb_glm_rd_streamer.sv
// tb_glm_rd_streamer: directed self-checking bench for glm_rd_streamer with MAX_OUTSTANDING=4.
module tb_glm_rd_streamer;
    import glm_rd_streamer_pkg::*;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic           almfull = 1'b0;
    t_ccip_clAddr   base_addr = '0;
    logic [31:0]    num_lines = '0;
    t_if_ccip_c0_Tx c0Tx;
    t_if_ccip_c0_Rx c0Rx = '0;
    logic           rd_valid, busy, done;
    logic [511:0]   rd_data;
    logic [15:0]    rd_tag;
    logic [31:0]    stat;

    glm_rd_streamer #(.MAX_OUTSTANDING(4), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_lines(num_lines),
        .c0TxAlmFull(almfull), .c0Tx(c0Tx), .c0Rx(c0Rx), .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_tag(rd_tag), .busy(busy), .done(done), .stat_almfull_cycles(stat)
    );

    always #5 clk = ~clk;

    typedef struct {logic [41:0] addr; logic [15:0] mdata; int c;} t_tx;
    typedef struct {logic [15:0] tag; t_ccip_c0_rsp typ; int due;} t_rsp;

    int          cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;
    bit          auto_rsp = 1'b0;
    t_tx         tx_q[$];
    logic [15:0] rd_q[$];
    t_rsp        rsp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor outputs and play back queued responses, one per cycle, all on the falling edge.
    always @(negedge clk) begin
        t_rsp r;
        if (c0Tx.valid) begin
            tx_q.push_back('{c0Tx.hdr.address, c0Tx.hdr.mdata, cyc});
            chk("hdr_misc", 64'({c0Tx.hdr.vc_sel, c0Tx.hdr.rsvd1, c0Tx.hdr.cl_len, c0Tx.hdr.req_type, c0Tx.hdr.rsvd0}), 64'h0);
            if (auto_rsp) rsp_q.push_back('{c0Tx.hdr.mdata, eRSP_RDLINE, cyc + 2});
        end
        if (rd_valid) begin
            rd_q.push_back(rd_tag);
            chk("rd_data_lo", rd_data[63:0], {4{rd_tag}});
            chk("rd_data_hi", rd_data[511:448], {4{rd_tag}});
        end
        c0Rx = '0;
        if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
            r = rsp_q.pop_front();
            c0Rx.rspValid      = 1'b1;
            c0Rx.hdr.mdata     = r.tag;
            c0Rx.hdr.resp_type = r.typ;
            c0Rx.data          = {32{r.tag}};
        end
    end

    task automatic step(int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic go(logic [41:0] b, logic [31:0] n);
        start = 1'b1;
        base_addr = b;
        num_lines = n;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(string tag, int lim);
        int k = 0;
        while (!done && k < lim) begin
            step();
            k++;
        end
        chk(tag, 64'(done), 64'h1);
    endtask

    task automatic wait_tx(string tag, int n, int lim);
        int k = 0;
        while (tx_q.size() < n && k < lim) begin
            step();
            k++;
        end
        chk(tag, 64'(tx_q.size() >= n), 64'h1);
    endtask

    task automatic clear_q();
        tx_q.delete();
        rd_q.delete();
    endtask

    task automatic push_rsp(logic [15:0] tag, t_ccip_c0_rsp typ, int due);
        rsp_q.push_back('{tag, typ, due});
    endtask

    initial begin
        int t0, ak, hits;
        logic [15:0] exp_tag [3];
        exp_tag[0] = 16'd2;
        exp_tag[1] = 16'd0;
        exp_tag[2] = 16'd1;
        step(3);
        chk("rst_valid", 64'(c0Tx.valid), 64'h0);
        chk("rst_hdr", 64'(c0Tx.hdr.address), 64'h0);
        chk("rst_rd_valid", 64'(rd_valid), 64'h0);
        chk("rst_rd_tag", 64'(rd_tag), 64'h0);
        chk("rst_rd_data", rd_data[63:0], 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_stat", 64'(stat), 64'h0);
        reset = 1'b0;
        step();

        go(42'h123, 32'd0);
        chk("zero_busy", 64'(busy), 64'h0);
        chk("zero_done", 64'(done), 64'h1);
        step(5);
        chk("zero_no_req", 64'(tx_q.size()), 64'h0);

        clear_q();
        auto_rsp = 1'b1;
        go(42'h1000, 32'd4);
        t0 = cyc;
        chk("basic_busy", 64'(busy), 64'h1);
        chk("basic_no_early_req", 64'(c0Tx.valid), 64'h0);
        chk("basic_done_clr", 64'(done), 64'h0);
        wait_done("basic_done", 40);
        chk("basic_idle", 64'(busy), 64'h0);
        chk("basic_nreq", 64'(tx_q.size()), 64'h4);
        for (int i = 0; i < 4 && i < tx_q.size(); i++) begin
            chk("basic_addr", 64'(tx_q[i].addr), 64'h1000 + 64'(i));
            chk("basic_mdata", 64'(tx_q[i].mdata), 64'(i));
            chk("basic_cycle", 64'(tx_q[i].c), 64'(t0 + 1 + i));
        end
        chk("basic_nrd", 64'(rd_q.size()), 64'h4);
        for (int i = 0; i < 4 && i < rd_q.size(); i++) chk("basic_tag", 64'(rd_q[i]), 64'(i));

        clear_q();
        auto_rsp = 1'b0;
        go(42'h2000, 32'd10);
        step(12);
        chk("cap_nreq", 64'(tx_q.size()), 64'h4);
        chk("cap_stalled", 64'(c0Tx.valid), 64'h0);
        push_rsp(16'd0, eRSP_UMSG, cyc);
        step(6);
        chk("cap_umsg_ignored", 64'(tx_q.size()), 64'h4);
        chk("cap_umsg_no_rd", 64'(rd_q.size()), 64'h0);
        push_rsp(16'd0, eRSP_RDLINE, cyc);
        push_rsp(16'd1, eRSP_RDLINE, cyc + 1);
        step(8);
        chk("cap_simul_nreq", 64'(tx_q.size()), 64'h6);
        auto_rsp = 1'b1;
        for (int i = 2; i < 6; i++) push_rsp(16'(i), eRSP_RDLINE, cyc);
        wait_done("cap_done", 80);
        chk("cap_total_req", 64'(tx_q.size()), 64'd10);
        chk("cap_total_rd", 64'(rd_q.size()), 64'd10);

        clear_q();
        go(42'h5000, 32'd8);
        wait_tx("af_start", 2, 20);
        almfull = 1'b1;
        ak = cyc;
        step(5);
        almfull = 1'b0;
        wait_done("af_done", 80);
        hits = 0;
        foreach (tx_q[i]) if (tx_q[i].c >= ak + 1 && tx_q[i].c <= ak + 5) hits++;
        chk("af_quiet", 64'(hits), 64'h0);
        chk("af_nreq", 64'(tx_q.size()), 64'd8);
        chk("af_nrd", 64'(rd_q.size()), 64'd8);
`ifdef GLM_RD_STATS_EN
        chk("af_stat", 64'(stat), 64'd5);
`else
        chk("af_stat", 64'(stat), 64'd0);
`endif

        clear_q();
        auto_rsp = 1'b0;
        go(42'h3FF_FFFF_FFFE, 32'd3);
        wait_tx("wrap_issue", 3, 20);
        start = 1'b1;
        base_addr = 42'h9999;
        num_lines = 32'd7;
        step();
        start = 1'b0;
        chk("busy_start_busy", 64'(busy), 64'h1);
        push_rsp(16'd2, eRSP_RDLINE, cyc);
        push_rsp(16'd0, eRSP_RDLINE, cyc + 1);
        push_rsp(16'd1, eRSP_RDLINE, cyc + 2);
        wait_done("wrap_done", 40);
        step(3);
        chk("wrap_nreq", 64'(tx_q.size()), 64'h3);
        if (tx_q.size() == 3) begin
            chk("wrap_addr0", 64'(tx_q[0].addr), 64'h3FF_FFFF_FFFE);
            chk("wrap_addr1", 64'(tx_q[1].addr), 64'h3FF_FFFF_FFFF);
            chk("wrap_addr2", 64'(tx_q[2].addr), 64'h0);
        end
        chk("wrap_nrd", 64'(rd_q.size()), 64'h3);
        for (int i = 0; i < 3 && i < rd_q.size(); i++) chk("wrap_tag", 64'(rd_q[i]), 64'(exp_tag[i]));
        chk("wrap_done_hold", 64'(done), 64'h1);

        clear_q();
        go(42'h7000, 32'd8);
        wait_tx("rst_issue", 3, 20);
        reset = 1'b1;
        step();
        chk("mrst_valid", 64'(c0Tx.valid), 64'h0);
        chk("mrst_hdr", 64'(c0Tx.hdr.address), 64'h0);
        chk("mrst_rd_tag", 64'(rd_tag), 64'h0);
        chk("mrst_rd_data", rd_data[63:0], 64'h0);
        chk("mrst_busy", 64'(busy), 64'h0);
        chk("mrst_done", 64'(done), 64'h0);
        chk("mrst_stat", 64'(stat), 64'h0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) push_rsp(16'(i), eRSP_RDLINE, cyc + i);
        step(8);
        chk("stale_no_rd", 64'(rd_q.size()), 64'h0);
        chk("stale_idle", 64'(busy), 64'h0);
        chk("stale_no_req", 64'(c0Tx.valid), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
